// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage sequencer for the external data SRAM.
// Stretches single-cycle loads/stores into timed SRAM cycles under stall.
module mem_access_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_en,
  input  logic              MEM_W_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              stall,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [31:0]       SRAM_DQ_out,
  input  logic [31:0]       SRAM_DQ_in,
  output logic              SRAM_DQ_oe,
  output logic              SRAM_WE_N
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [31:0] BASE = 32'(BASE_ADDR);
  localparam logic [3:0]  LAST = 4'(WAIT_CYCLES);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              req;
  logic              accept;
  logic              capture;

  assign req = MEM_R_en | MEM_W_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    capture    = 1'b0;
    ready      = 1'b0;
    stall      = 1'b0;
    SRAM_DQ_oe = 1'b0;
    SRAM_WE_N  = 1'b1;
    unique case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          accept  = 1'b1;
          state_d = ACCESS;
          cnt_d   = 4'd1;
        end
      end
      ACCESS: begin
        stall      = 1'b1;
        SRAM_DQ_oe = wr_q;
        // strobe released on the final cycle to hold data past WE_N rise
        SRAM_WE_N  = !(wr_q && (cnt_q < LAST));
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          capture = !wr_q;
          state_d = DONE;
          cnt_d   = 4'd0;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= 32'd0;
      read_data <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q   <= MEM_W_en;
        addr_q <= ADDR_W'((address - BASE) >> 2);
        data_q <= write_data;
      end
      if (capture) begin
        read_data <= SRAM_DQ_in;
      end
    end
  end

  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_out = data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: random + directed bench for mem_access_ctrl
// against a transaction-timeline model and an SRAM emulator.
module tb_mem_access_ctrl;

  localparam int BASE = 1024;
  localparam int AW   = 18;
  localparam int W    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r_en = 1'b0;
  logic          w_en = 1'b0;
  logic [31:0]   addr = 32'd0;
  logic [31:0]   wdata = 32'd0;
  logic [31:0]   sram_in = 32'd0;
  logic [31:0]   read_data;
  logic [31:0]   sram_out;
  logic          ready;
  logic          stall;
  logic          oe;
  logic          we_n;
  logic [AW-1:0] sram_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .BASE_ADDR  (BASE),
    .ADDR_W     (AW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_en   (r_en),
    .MEM_W_en   (w_en),
    .address    (addr),
    .write_data (wdata),
    .read_data  (read_data),
    .ready      (ready),
    .stall      (stall),
    .SRAM_ADDR  (sram_addr),
    .SRAM_DQ_out(sram_out),
    .SRAM_DQ_in (sram_in),
    .SRAM_DQ_oe (oe),
    .SRAM_WE_N  (we_n)
  );

  function automatic logic [31:0] seed_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [AW-1:0] map(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return AW'(off / 32'd4);
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return 32'(BASE) + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
  endfunction

  logic [31:0] sram_mem [logic [AW-1:0]];

  // external SRAM: write while WE_N low, present read data before the edge
  always @(negedge clk) begin
    if (!we_n) sram_mem[sram_addr] = sram_out;
    sram_in = sram_mem.exists(sram_addr) ? sram_mem[sram_addr]
                                         : seed_word(sram_addr);
  end

  logic [31:0]   model_mem [logic [AW-1:0]];
  int            cyc = 0;
  int            t0 = -1;
  int            mk = -1;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_a = '0;
  logic [31:0]   m_d = 32'd0;
  logic [31:0]   rd_exp = 32'd0;
  int            n_stall = 0;
  int            n_wel = 0;
  int            n_ready = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic acc;
    logic e_stall;
    logic e_ready;
    logic e_oe;
    logic e_wen;
    acc     = (mk >= 1) && (mk <= W);
    e_stall = (mk >= 0) && (mk <= W);
    e_ready = (mk == W + 1);
    e_oe    = acc && m_wr;
    e_wen   = !(m_wr && (mk >= 1) && (mk <= W - 1));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("ready", 32'(ready), 32'(e_ready));
    chk("dq_oe", 32'(oe), 32'(e_oe));
    chk("we_n", 32'(we_n), 32'(e_wen));
    chk("read_data", read_data, rd_exp);
    if (acc) chk("sram_addr", 32'(sram_addr), 32'(m_a));
    if (e_oe) chk("sram_dout", sram_out, m_d);
    if (!rst) begin
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dout", sram_out, 32'd0);
    end
    n_stall += int'(stall);
    n_wel   += int'(!we_n);
    n_ready += int'(ready);
  endtask

  task automatic step(input logic rv, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst   = rv;
    r_en  = r;
    w_en  = w;
    addr  = a;
    wdata = d;
    cyc++;
    if (!rv) begin
      t0     = -1;
      rd_exp = 32'd0;
    end else if (t0 >= 0 && cyc - t0 > W + 1) begin
      t0 = -1;
    end
    if (rv && t0 < 0 && (r || w)) begin
      t0   = cyc;
      m_wr = w;
      m_a  = map(a);
      m_d  = d;
    end
    mk = (t0 >= 0) ? cyc - t0 : -1;
    // a write lands once one strobe-low edge has gone by
    if (m_wr && mk == 2) model_mem[m_a] = m_d;
    if (mk == W + 1 && !m_wr)
      rd_exp = model_mem.exists(m_a) ? model_mem[m_a] : seed_word(m_a);
    @(negedge clk);
    compare();
  endtask

  task automatic xact(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] a1,
                      output logic [31:0] d1, output logic rdy,
                      output logic [31:0] rd);
    a1 = 32'd0;
    d1 = 32'd0;
    step(1'b1, r, w, a, d);
    for (int k = 1; k <= W + 1; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, $urandom);
      if (k == 1) begin
        a1 = 32'(sram_addr);
        d1 = sram_out;
      end
    end
    rdy = ready;
    rd  = read_data;
  endtask

  initial begin
    logic [31:0] a1;
    logic [31:0] d1;
    logic [31:0] rd;
    logic        rdy;
    int          s0;
    int          w0;
    int          r0;
    #1 rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    s0 = n_stall;
    r0 = n_ready;
    repeat (10) step(1'b1, 1'b0, 1'b0, $urandom, $urandom);
    chk("idle_stall", 32'(n_stall - s0), 32'd0);
    chk("idle_ready", 32'(n_ready - r0), 32'd0);
    chk("idle_rd", read_data, 32'd0);

    s0 = n_stall;
    w0 = n_wel;
    r0 = n_ready;
    xact(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, a1, d1, rdy, rd);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("wr_stall_cycles", 32'(n_stall - s0), 32'd6);
    chk("wr_we_cycles", 32'(n_wel - w0), 32'd4);
    chk("wr_ready_pulses", 32'(n_ready - r0), 32'd1);
    chk("wr_addr", a1, 32'd2);
    chk("wr_dout", d1, 32'hDEADBEEF);
    chk("wr_ready_at_6", 32'(rdy), 32'd1);

    s0 = n_stall;
    xact(1'b1, 1'b0, 32'd1032, 32'd0, a1, d1, rdy, rd);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rd_stall_cycles", 32'(n_stall - s0), 32'd6);
    chk("rd_ready", 32'(rdy), 32'd1);
    chk("rd_data", rd, 32'hDEADBEEF);

    w0 = n_wel;
    xact(1'b1, 1'b1, 32'd1024, 32'h12345678, a1, d1, rdy, rd);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("both_we_cycles", 32'(n_wel - w0), 32'd4);
    chk("both_addr", a1, 32'd0);
    chk("both_rd_kept", rd, 32'hDEADBEEF);

    s0 = n_stall;
    xact(1'b1, 1'b0, 32'd1024, 32'd0, a1, d1, rdy, rd);
    chk("b2b_rd_data", rd, 32'h12345678);
    xact(1'b0, 1'b1, 32'd1036, 32'h55AA33CC, a1, d1, rdy, rd);
    chk("b2b_stall_cycles", 32'(n_stall - s0), 32'd12);
    chk("b2b_wr_addr", a1, 32'd3);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    xact(1'b1, 1'b0, 32'd0, 32'd0, a1, d1, rdy, rd);
    chk("wrap_addr", a1, 32'h3FF00);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    step(1'b1, 1'b0, 1'b1, 32'(BASE + 40), 32'hCAFEF00D);
    step(1'b1, 1'b0, 1'b0, $urandom, $urandom);
    step(1'b1, 1'b0, 1'b0, $urandom, $urandom);
    r0 = n_ready;
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("abort_we_n", 32'(we_n), 32'd1);
    chk("abort_stall", 32'(stall), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (12) step(1'b1, 1'b0, 1'b0, $urandom, $urandom);
    chk("abort_no_ready", 32'(n_ready - r0), 32'd0);

    repeat (2500) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end else begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rand_addr(), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
